// File: rtl/i2c_target.sv
// i2c_target: I2C target with address match, 16x8 register file, auto-incrementing pointer and host write port
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h1D,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       host_we,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       wr_stb,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
  } state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl, sda, scl_d, sda_d, scl_rise, scl_fall, start, stop;
  logic [7:0] regs [16];
  logic [7:0] sr;
  logic [3:0] cnt, ptr, nxt;
  logic mack, match, done;
  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];
  assign nxt = ptr + 4'd1;
  assign match = sr[7:1] == ADDR && sr[7:1] != 7'd0;
  assign done = scl_fall && cnt == 4'd8;
  always_comb begin
    state_n = state;
    case (state)
      S_ADDR:     if (done) state_n = match ? S_ADDR_ACK : S_WAIT_STOP;
      S_ADDR_ACK: if (scl_fall) state_n = sr[0] ? S_RD : S_PTR;
      S_PTR:      if (done) state_n = S_PTR_ACK;
      S_PTR_ACK:  if (scl_fall) state_n = S_WR;
      S_WR:       if (done) state_n = S_WR_ACK;
      S_WR_ACK:   if (scl_fall) state_n = S_WR;
      S_RD:       if (done) state_n = S_RD_ACK;
      S_RD_ACK:   if (scl_fall) state_n = mack ? S_WAIT_STOP : S_RD;
      default:    ;
    endcase
    state_n = start ? S_ADDR : stop ? S_IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start <= 1'b0;
      stop <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      wr_stb <= 1'b0;
      wr_addr <= 4'd0;
      wr_data <= 8'd0;
      ptr <= 4'd0;
      cnt <= 4'd0;
      sr <= 8'd0;
      mack <= 1'b1;
      regs <= '{default: 8'h00};
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d <= scl;
      sda_d <= sda;
      scl_rise <= scl & ~scl_d;
      scl_fall <= ~scl & scl_d;
      start <= scl & scl_d & sda_d & ~sda;
      stop <= scl & scl_d & ~sda_d & sda;
      wr_stb <= 1'b0;
      if (host_we) regs[host_addr] <= host_wdata;
      if (start || stop) begin
        cnt <= 4'd0;
        sda_oe <= 1'b0;
        busy <= busy & start;
      end else if (scl_rise) begin
        if ((state == S_ADDR || state == S_PTR || state == S_WR) && cnt != 4'd8) begin
          sr <= {sr[6:0], sda_d};
          cnt <= cnt + 4'd1;
        end
        if (state == S_RD_ACK) mack <= sda_d;
      end else if (scl_fall) begin
        case (state)
          S_ADDR: if (cnt == 4'd8) begin
            sda_oe <= match;
            busy <= match;
          end
          S_ADDR_ACK: if (sr[0]) begin
            sda_oe <= ~regs[ptr][7];
            sr <= {regs[ptr][6:0], 1'b0};
            cnt <= 4'd1;
          end else begin
            sda_oe <= 1'b0;
            cnt <= 4'd0;
          end
          S_PTR: if (cnt == 4'd8) begin
            ptr <= sr[3:0];
            sda_oe <= 1'b1;
          end
          S_PTR_ACK, S_WR_ACK: begin
            sda_oe <= 1'b0;
            cnt <= 4'd0;
          end
          S_WR: if (cnt == 4'd8) begin
            regs[ptr] <= sr;
            wr_stb <= 1'b1;
            wr_addr <= ptr;
            wr_data <= sr;
            ptr <= nxt;
            sda_oe <= 1'b1;
          end
          S_RD: if (cnt == 4'd8) sda_oe <= 1'b0;
          else begin
            sda_oe <= ~sr[7];
            sr <= {sr[6:0], 1'b0};
            cnt <= cnt + 4'd1;
          end
          S_RD_ACK: begin
            ptr <= nxt;
            if (!mack) begin
              sda_oe <= ~regs[nxt][7];
              sr <= {regs[nxt][6:0], 1'b0};
              cnt <= 4'd1;
            end else busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master bench with vector table and directed corner sequences
module tb_i2c_target;
  logic clk = 1'b0, rst = 1'b0, scl = 1'b1, msda = 1'b1, sda_line;
  logic sda_oe, wr_stb, busy, host_we = 1'b0;
  logic [3:0] host_addr = 4'd0, wr_addr;
  logic [7:0] host_wdata = 8'd0, wr_data;
  int n_cmp = 0, n_bad = 0, stb_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [3:0] stb_a [$];
  logic [7:0] stb_d [$];
  typedef struct { logic [7:0] dev; logic [3:0] ptr; logic [7:0] data; logic ack; logic [7:0] rd; } vec_t;
  vec_t tbl [7];
  assign sda_line = msda & ~sda_oe;
  always #5 clk = ~clk;
  i2c_target dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  always @(posedge clk) begin
    if (wr_stb) begin
      stb_cnt <= stb_cnt + 1;
      stb_a.push_back(wr_addr);
      stb_d.push_back(wr_data);
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [11:0] stb_at(input int i);
    if (i < stb_a.size()) return {stb_a[i], stb_d[i]};
    return 12'hfff;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_io(input logic b, output logic r);
    tick(3); msda = b; tick(5); scl = 1'b1; tick(8); r = sda_line; scl = 1'b0;
  endtask
  task automatic i2c_start;
    tick(3); msda = 1'b1; tick(5); scl = 1'b1; tick(5); msda = 1'b0; tick(5); scl = 1'b0;
  endtask
  task automatic i2c_stop;
    tick(3); msda = 1'b0; tick(5); scl = 1'b1; tick(5); msda = 1'b1; tick(5);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, ack);
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(nack, r);
  endtask
  task automatic read_reg(input logic [3:0] p, output logic [7:0] d);
    logic a;
    i2c_start; send_byte(8'h3A, a); send_byte({4'h0, p}, a);
    i2c_start; send_byte(8'h3B, a); recv_byte(1'b1, d); i2c_stop;
  endtask
  initial begin
    logic a, r;
    logic [7:0] d;
    int s, o, b;
    tbl[0] = '{8'h3A, 4'h9, 8'hC3, 1'b0, 8'hC3};
    tbl[1] = '{8'h3A, 4'hF, 8'h81, 1'b0, 8'h81};
    tbl[2] = '{8'h3C, 4'h9, 8'h00, 1'b1, 8'hC3};
    tbl[3] = '{8'h00, 4'h9, 8'h11, 1'b1, 8'hC3};
    tbl[4] = '{8'h3A, 4'h9, 8'h7E, 1'b0, 8'h7E};
    tbl[5] = '{8'h38, 4'h4, 8'h55, 1'b1, 8'h00};
    tbl[6] = '{8'h3A, 4'h1, 8'hE7, 1'b0, 8'hE7};
    tick(4);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset wr_stb", wr_stb, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    rst = 1'b1;
    tick(4);
    i2c_start;
    send_byte(8'h3A, a); check("write addr ack", a, 0);
    send_byte(8'h05, a); check("write ptr ack", a, 0);
    send_byte(8'hA5, a); check("write data0 ack", a, 0);
    send_byte(8'h5A, a); check("write data1 ack", a, 0);
    check("busy in write", busy, 1);
    i2c_stop;
    check("busy after stop", busy, 0);
    check("write stb count", stb_cnt, 2);
    check("write stb0", stb_at(0), {4'h5, 8'hA5});
    check("write stb1", stb_at(1), {4'h6, 8'h5A});
    read_reg(4'h5, d); check("regs5", d, 8'hA5);
    read_reg(4'h6, d); check("regs6", d, 8'h5A);
    host_we = 1'b1; host_addr = 4'hE; host_wdata = 8'h11; tick(1);
    host_addr = 4'hF; host_wdata = 8'h22; tick(1);
    host_we = 1'b0;
    i2c_start; send_byte(8'h3A, a); send_byte(8'h0E, a);
    i2c_start; send_byte(8'h3B, a); check("read addr ack", a, 0);
    recv_byte(1'b0, d); check("read byte0", d, 8'h11);
    recv_byte(1'b0, d); check("read byte1", d, 8'h22);
    recv_byte(1'b1, d); check("read byte2 wrap", d, 8'h00);
    i2c_stop;
    s = stb_cnt; o = oe_cnt; b = busy_cnt;
    i2c_start; send_byte(8'h3C, a); check("wrong addr nack", a, 1);
    send_byte(8'h05, a); send_byte(8'h77, a); i2c_stop;
    check("wrong addr sda_oe", oe_cnt - o, 0);
    check("wrong addr busy", busy_cnt - b, 0);
    check("wrong addr stb", stb_cnt - s, 0);
    s = stb_cnt;
    i2c_start; send_byte(8'h3A, a); send_byte(8'h02, a);
    bit_io(1'b1, r); bit_io(1'b0, r); bit_io(1'b1, r); bit_io(1'b0, r);
    i2c_stop;
    check("abort stb", stb_cnt - s, 0);
    check("abort busy", busy, 0);
    read_reg(4'h2, d); check("abort regs2", d, 8'h00);
    i2c_start; send_byte(8'h3A, a); send_byte(8'h02, a); send_byte(8'h3C, a);
    check("post-abort data ack", a, 0);
    i2c_stop;
    check("post-abort stb", stb_at(s), {4'h2, 8'h3C});
    read_reg(4'h2, d); check("post-abort regs2", d, 8'h3C);
    for (int i = 0; i < 7; i++) begin
      s = stb_cnt;
      i2c_start; send_byte(tbl[i].dev, a);
      check($sformatf("tbl%0d addr ack", i), a, tbl[i].ack);
      send_byte({4'h0, tbl[i].ptr}, a); send_byte(tbl[i].data, a); i2c_stop;
      check($sformatf("tbl%0d stb count", i), stb_cnt - s, tbl[i].ack ? 0 : 1);
      read_reg(tbl[i].ptr, d);
      check($sformatf("tbl%0d readback", i), d, tbl[i].rd);
    end
    s = stb_cnt;
    i2c_start; send_byte(8'h3A, a); send_byte(8'h03, a);
    for (int i = 7; i >= 0; i--) bit_io(d[0] ^ d[0] ^ (8'h99 >> i) & 1'b1, r);
    tick(3); host_we = 1'b1; host_addr = 4'h3; host_wdata = 8'h77;
    tick(1); host_we = 1'b0; msda = 1'b1;
    tick(4); scl = 1'b1; tick(8); a = sda_line; scl = 1'b0;
    check("collision ack", a, 0);
    i2c_stop;
    check("collision stb", stb_at(s), {4'h3, 8'h99});
    read_reg(4'h3, d); check("collision regs3", d, 8'h99);
    i2c_start; send_byte(8'h3A, a); send_byte(8'h05, a);
    i2c_start; send_byte(8'h3B, a);
    bit_io(1'b1, r); bit_io(1'b1, r); bit_io(1'b1, r);
    tick(8); scl = 1'b1; tick(4);
    check("mid-read bit4 driven", sda_oe, 1);
    rst = 1'b0; tick(1);
    check("mid-read reset sda_oe", sda_oe, 0);
    check("mid-read reset busy", busy, 0);
    check("mid-read reset wr_stb", wr_stb, 0);
    check("mid-read reset wr_addr", wr_addr, 0);
    check("mid-read reset wr_data", wr_data, 0);
    rst = 1'b1; msda = 1'b1; tick(2);
    s = stb_cnt;
    i2c_start;
    send_byte(8'h3A, a); check("post-reset addr ack", a, 0);
    send_byte(8'h07, a); check("post-reset ptr ack", a, 0);
    send_byte(8'h42, a); check("post-reset data ack", a, 0);
    i2c_stop;
    check("post-reset stb", stb_at(s), {4'h7, 8'h42});
    read_reg(4'h7, d); check("post-reset regs7", d, 8'h42);
    read_reg(4'h5, d); check("post-reset regs5 cleared", d, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
